// File: rtl/rt_pixel_out.sv
// Buffers the ray-tracing core's pixel stream in a show-ahead FIFO and re-emits it as an AXI4-Stream master with SOF (tuser) / EOF (tlast).
// Latency: 1 cycle from in_valid to tvalid. The core has no ready; a registered stall keeps STALL_MARGIN slots free for pixels already in flight.
module rt_pixel_out #(
    parameter int PIXEL_W      = 16,
    parameter int DEPTH        = 16,
    parameter int STALL_MARGIN = 6
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic [PIXEL_W-1:0]       in_pixel,
    output logic                     stall,
    output logic [PIXEL_W-1:0]       m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_done,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = PIXEL_W + 2;
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] STALL_LVL = LW'(DEPTH - STALL_MARGIN);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          expect_sof_q, expect_sof_d;
    logic          stall_q, frame_done_q, overflow_q;
    logic          push, pop, not_empty;
    logic [EW-1:0] head;

    // Head is forced to zero while empty so stale storage never leaks onto the bus.
    assign not_empty = (level_q != '0);
    assign head      = not_empty ? mem_q[rd_ptr_q] : '0;
    assign pop       = not_empty && m_axis_tready;
    assign push      = in_valid && ((level_q < FULL_LVL) || pop);

    always_comb begin
        level_d      = level_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        expect_sof_d = expect_sof_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        if (push) begin
            wr_ptr_d     = wr_ptr_q + AW'(1);
            expect_sof_d = in_last;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {expect_sof_q, in_last, in_pixel};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            expect_sof_q <= 1'b1;
            stall_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            expect_sof_q <= expect_sof_d;
            stall_q      <= (level_d >= STALL_LVL);
            frame_done_q <= pop && head[EW-2];
            overflow_q   <= overflow_q || (in_valid && !push);
        end
    end

    assign stall         = stall_q;
    assign m_axis_tvalid = not_empty;
    assign m_axis_tdata  = head[PIXEL_W-1:0];
    assign m_axis_tlast  = head[EW-2];
    assign m_axis_tuser  = head[EW-1];
    assign level         = level_q;
    assign frame_done    = frame_done_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_rt_pixel_out.sv
// Directed bench for rt_pixel_out: hand-computed vectors plus a cycle model/scoreboard sampled on the falling edge.
module tb_rt_pixel_out;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_pixel = '0;
    logic        m_axis_tready = 1'b0;
    logic        stall, m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_done, overflow;
    logic [15:0] m_axis_tdata;
    logic [4:0]  level;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    rt_pixel_out #(.PIXEL_W(16), .DEPTH(16), .STALL_MARGIN(6)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_last(in_last), .in_pixel(in_pixel),
        .stall(stall),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .level(level),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: state predicted for the upcoming rising edge.
    logic [17:0] exp_q[$];
    logic [17:0] e;
    int  m_level, nl;
    bit  m_stall, m_fd, m_ovf, m_sof, pop_m, push_m, last_m;
    int  fd_cnt = 0;
    int  pop_cnt = 0;
    bit  stall_seen = 0;

    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            m_level = 0; m_stall = 0; m_fd = 0; m_ovf = 0; m_sof = 1;
            exp_q.delete();
        end else begin
            pop_m  = (m_level != 0) && m_axis_tready;
            push_m = in_valid && ((m_level < 16) || pop_m);
            chk("m_level", level, m_level);
            chk("m_tvalid", m_axis_tvalid, m_level != 0);
            chk("m_stall", stall, m_stall);
            chk("m_frame_done", frame_done, m_fd);
            chk("m_overflow", overflow, m_ovf);
            if (frame_done) fd_cnt++;
            if (stall) stall_seen = 1;
            if (m_level == 0) chk("m_empty_head", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, 0);
            last_m = 0;
            if (pop_m && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_tdata", m_axis_tdata, e[15:0]);
                chk("sb_tlast", m_axis_tlast, e[16]);
                chk("sb_tuser", m_axis_tuser, e[17]);
                last_m = e[16];
                pop_cnt++;
            end
            if (push_m) begin
                exp_q.push_back({m_sof, in_last, in_pixel});
                m_sof = in_last;
            end
            if (in_valid && !push_m) m_ovf = 1;
            nl = m_level + int'(push_m) - int'(pop_m);
            m_stall = (nl >= 10);
            m_fd    = pop_m && last_m;
            m_level = nl;
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    bit pat_u [5] = '{1, 0, 0, 1, 0};
    bit pat_l [5] = '{0, 0, 1, 0, 1};
    int pat_d [5] = '{500, 501, 502, 600, 601};
    int n, base, g;

    initial begin
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2;
        chk("rst_level", level, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_head", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, 0);
        step();
        step();
        resetn = 1'b1;

        // Reset asserted mid-stream with 5 entries held
        m_axis_tready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_pixel = 16'(100 + i); in_last = 0;
            step();
        end
        in_valid = 0;
        chk("mid_level5", level, 5);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_overflow", overflow, 0);
        step();
        step();
        resetn = 1'b1;
        in_valid = 1; in_pixel = 16'd7; in_last = 0;
        step();
        in_valid = 0;
        chk("post_rst_tvalid", m_axis_tvalid, 1);
        chk("post_rst_tdata", m_axis_tdata, 7);
        chk("post_rst_tuser", m_axis_tuser, 1);
        m_axis_tready = 1;
        repeat (3) step();

        // Streaming 64 pixels at full rate
        base = fd_cnt;
        stall_seen = 0;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1; in_pixel = 16'(i); in_last = (i == 63);
            step();
            if (i == 0) begin
                chk("stream_lat_tvalid", m_axis_tvalid, 1);
                chk("stream_lat_tdata", m_axis_tdata, 0);
            end
        end
        in_valid = 0; in_last = 0;
        repeat (3) step();
        chk("stream_fd_count", fd_cnt - base, 1);
        chk("stream_no_stall", stall_seen, 0);
        chk("stream_empty", level, 0);

        // Backpressure: core keeps pushing 5 beats after stall
        m_axis_tready = 0;
        n = 0;
        while (!stall && n < 20) begin
            in_valid = 1; in_pixel = 16'(200 + n); in_last = 0;
            step();
            n++;
        end
        chk("bp_stall_after", n, 10);
        repeat (5) begin
            in_pixel = 16'(200 + n);
            step();
            n++;
        end
        in_valid = 0;
        chk("bp_level15", level, 15);
        chk("bp_no_overflow", overflow, 0);
        m_axis_tready = 1;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("bp_drain_level", level, 15 - k);
            chk("bp_drain_stall", stall, (15 - k) >= 10);
        end
        chk("bp_drained", m_axis_tvalid, 0);

        // Full FIFO with simultaneous push/pop, then a dropped push
        m_axis_tready = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1; in_pixel = 16'(300 + i);
            step();
        end
        chk("full_level", level, 16);
        in_pixel = 16'd400; m_axis_tready = 1;
        step();
        chk("full_pp_level", level, 16);
        chk("full_pp_overflow", overflow, 0);
        in_pixel = 16'd401; m_axis_tready = 0;
        step();
        in_valid = 0;
        chk("full_drop_level", level, 16);
        chk("full_drop_overflow", overflow, 1);
        m_axis_tready = 1;
        repeat (17) step();
        chk("full_drained", level, 0);
        chk("full_overflow_sticky", overflow, 1);

        // Frame boundaries with a held tlast beat
        do_reset();
        m_axis_tready = 0;
        for (int j = 0; j < 5; j++) begin
            in_valid = 1; in_pixel = 16'(pat_d[j]); in_last = pat_l[j];
            step();
        end
        in_valid = 0; in_last = 0;
        base = fd_cnt;
        for (int j = 0; j < 5; j++) begin
            chk("frm_tdata", m_axis_tdata, pat_d[j]);
            chk("frm_tuser", m_axis_tuser, pat_u[j]);
            chk("frm_tlast", m_axis_tlast, pat_l[j]);
            if (j == 2) begin
                repeat (4) begin
                    step();
                    chk("hold_tvalid", m_axis_tvalid, 1);
                    chk("hold_tdata", m_axis_tdata, 502);
                    chk("hold_tlast", m_axis_tlast, 1);
                    chk("hold_tuser", m_axis_tuser, 0);
                end
            end
            m_axis_tready = 1;
            step();
            m_axis_tready = 0;
        end
        step();
        chk("frm_fd_count", fd_cnt - base, 2);

        // Pointer wrap: 40 frames of 7 with random ready, core honouring stall
        do_reset();
        base = pop_cnt;
        for (int f = 0; f < 40; f++) begin
            for (int p = 0; p < 7; p++) begin
                g = 0;
                while (stall && g < 200) begin
                    in_valid = 0; m_axis_tready = 1'($urandom_range(0, 1));
                    step();
                    g++;
                end
                in_valid = 1; in_pixel = 16'(f * 16 + p); in_last = (p == 6);
                m_axis_tready = 1'($urandom_range(0, 1));
                step();
                chk("wrap_level_max", level <= 16, 1);
            end
        end
        in_valid = 0; in_last = 0; m_axis_tready = 1;
        repeat (20) step();
        chk("wrap_beats", pop_cnt - base, 280);
        chk("wrap_overflow", overflow, 0);
        chk("wrap_empty", level, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
